// File: rtl/sdram_host_cmd_packer.sv
// Host-side command packer: splits Avalon-style bursts into single-beat SDRAM
// command words and pushes them into the command FIFO through a one-entry stage.
`ifndef SDRM_BUS
`define SDRM_BUS (1 + BE_W + ADDR_W + DATA_W)
`endif

module sdram_host_cmd_packer #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 16,
    parameter int BE_W    = 2,
    parameter int BURST_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   host_req,
    input  logic                   host_rnw,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [BE_W-1:0]        host_be,
    input  logic [DATA_W-1:0]      host_wdata,
    input  logic [BURST_W-1:0]     host_burstcount,
    output logic                   host_wait,
    output logic                   fifo_wr,
    output logic [`SDRM_BUS-1:0]   fifo_wr_data,
    input  logic                   fifo_full,
    output logic                   busy
);

    localparam int BUS_W = 1 + BE_W + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_s_valid;
    logic [BUS_W-1:0]     r_s_data;
    logic [BURST_W-1:0]   r_beat;
    logic [BURST_W-1:0]   r_count;
    logic [ADDR_W-1:0]    r_base;
    logic [BE_W-1:0]      r_be;

    logic                 w_s_ready;
    logic                 w_fifo_wr;
    logic                 w_wait;
    logic                 w_load;
    logic [BUS_W-1:0]     w_load_data;
    logic [BURST_W-1:0]   w_eff_cnt;
    logic                 w_last_beat;
    logic [ADDR_W-1:0]    w_beat_addr;

    assign w_s_ready   = ~r_s_valid | ~fifo_full;
    assign w_fifo_wr   = r_s_valid & ~fifo_full;
    assign w_eff_cnt   = (host_burstcount == {BURST_W{1'b0}}) ? {{(BURST_W-1){1'b0}}, 1'b1} : host_burstcount;
    assign w_last_beat = (r_beat == (r_count - {{(BURST_W-1){1'b0}}, 1'b1}));
    assign w_beat_addr = r_base + ADDR_W'(r_beat);

    assign fifo_wr      = w_fifo_wr;
    assign fifo_wr_data = r_s_data;
    assign host_wait    = w_wait;
    assign busy         = (r_state != S_IDLE) | r_s_valid;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load && (w_eff_cnt > {{(BURST_W-1){1'b0}}, 1'b1})) begin
                    w_state_nxt = host_rnw ? S_RD : S_WR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD, S_WR: begin
                if (w_load && w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and next staged word; read bursts ignore the host entirely
    always_comb begin
        w_wait      = 1'b0;
        w_load      = 1'b0;
        w_load_data = {BUS_W{1'b0}};
        case (r_state)
            S_IDLE: begin
                w_wait      = ~w_s_ready;
                w_load      = host_req & w_s_ready;
                w_load_data = {host_rnw, host_be, host_addr,
                               host_rnw ? {DATA_W{1'b0}} : host_wdata};
            end
            S_RD: begin
                w_wait      = 1'b1;
                w_load      = w_s_ready;
                w_load_data = {1'b1, r_be, w_beat_addr, {DATA_W{1'b0}}};
            end
            S_WR: begin
                w_wait      = ~w_s_ready;
                w_load      = host_req & w_s_ready;
                w_load_data = {1'b0, host_be, w_beat_addr, host_wdata};
            end
            default: begin
                w_wait      = 1'b0;
                w_load      = 1'b0;
                w_load_data = {BUS_W{1'b0}};
            end
        endcase
    end

    // Output stage and burst bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_valid <= 1'b0;
            r_s_data  <= {BUS_W{1'b0}};
            r_beat    <= {BURST_W{1'b0}};
            r_count   <= {BURST_W{1'b0}};
            r_base    <= {ADDR_W{1'b0}};
            r_be      <= {BE_W{1'b0}};
        end else begin
            if (w_load) begin
                r_s_valid <= 1'b1;
                r_s_data  <= w_load_data;
            end else if (w_fifo_wr) begin
                r_s_valid <= 1'b0;
            end else begin
                r_s_valid <= r_s_valid;
            end

            if (r_state == S_IDLE) begin
                if (w_load && (w_eff_cnt > {{(BURST_W-1){1'b0}}, 1'b1})) begin
                    r_beat  <= {{(BURST_W-1){1'b0}}, 1'b1};
                    r_base  <= host_addr;
                    r_be    <= host_be;
                    r_count <= w_eff_cnt;
                end else begin
                    r_beat  <= {BURST_W{1'b0}};
                end
            end else if (w_load) begin
                r_beat <= w_last_beat ? {BURST_W{1'b0}} : (r_beat + {{(BURST_W-1){1'b0}}, 1'b1});
            end else begin
                r_beat <= r_beat;
            end
        end
    end

endmodule

// File: tb/tb_sdram_host_cmd_packer.sv
// Randomized bench: expected command words are derived from the issued bursts
// and compared, in order, against every FIFO push.
module tb_sdram_host_cmd_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_req = 1'b0;
    logic        host_rnw = 1'b0;
    logic [21:0] host_addr = 22'd0;
    logic [1:0]  host_be = 2'd0;
    logic [15:0] host_wdata = 16'd0;
    logic [3:0]  host_burstcount = 4'd0;
    logic        host_wait;
    logic        fifo_wr;
    logic [40:0] fifo_wr_data;
    logic        fifo_full = 1'b0;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          push_cnt = 0;
    bit          mon_en = 1'b0;
    bit          full_rand = 1'b0;
    logic [40:0] exp_q[$];

    sdram_host_cmd_packer dut (
        .clk(clk), .reset_n(reset_n), .host_req(host_req), .host_rnw(host_rnw),
        .host_addr(host_addr), .host_be(host_be), .host_wdata(host_wdata),
        .host_burstcount(host_burstcount), .host_wait(host_wait), .fifo_wr(fifo_wr),
        .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] pack(input logic rnw, input logic [1:0] be,
                                         input logic [21:0] addr, input logic [15:0] data);
        return {rnw, be, addr, rnw ? 16'h0000 : data};
    endfunction

    // Push monitor: every FIFO write must match the oldest expected word
    always begin
        @(negedge clk);
        #2;
        if (mon_en && reset_n && fifo_wr) begin
            push_cnt++;
            check_val("wr_while_full", {63'd0, fifo_full}, 64'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_push", {23'd0, fifo_wr_data}, 64'd0 - 64'd1);
            end else begin
                check_val("word", {23'd0, fifo_wr_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic set_full();
        fifo_full = full_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        host_req   = 1'b0;
        host_addr  = 22'($urandom);
        host_wdata = 16'($urandom);
        host_be    = 2'($urandom);
        set_full();
    endtask

    // Present one beat and hold it until it is accepted at a rising edge
    task automatic drive_beat(input logic rnw, input logic [21:0] addr, input logic [1:0] be,
                              input logic [15:0] data, input logic [3:0] cnt);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            host_req = 1'b1; host_rnw = rnw; host_addr = addr;
            host_be = be; host_wdata = data; host_burstcount = cnt;
            set_full();
            #1;
            if (!host_wait) begin
                @(posedge clk);
                break;
            end
            n++;
            if (n > 300) begin
                check_val("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic wr_beat(input logic [21:0] exp_addr, input logic [21:0] bus_addr,
                           input logic [1:0] be, input logic [15:0] data, input logic [3:0] cnt);
        drive_beat(1'b0, bus_addr, be, data, cnt);
        exp_q.push_back(pack(1'b0, be, exp_addr, data));
    endtask

    task automatic burst(input logic rnw, input logic [21:0] addr, input logic [3:0] cnt, input int gap_pct);
        int          eff;
        logic [1:0]  be;
        logic [15:0] d;
        eff = (cnt == 4'd0) ? 1 : int'(cnt);
        if (rnw) begin
            be = 2'($urandom);
            drive_beat(1'b1, addr, be, 16'($urandom), cnt);
            for (int i = 0; i < eff; i++) exp_q.push_back(pack(1'b1, be, addr + 22'(i), 16'h0));
        end else begin
            for (int i = 0; i < eff; i++) begin
                while (int'($urandom_range(0, 99)) < gap_pct) idle_cycle();
                be = 2'($urandom);
                d  = 16'($urandom);
                if (i == 0) wr_beat(addr, addr, be, d, cnt);
                else        wr_beat(addr + 22'(i), 22'($urandom), be, d, 4'($urandom));
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        full_rand = 1'b0;
        n = 0;
        do begin
            idle_cycle();
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 200);
        check_val(tag, {32'd0, exp_q.size()}, 64'd0);
    endtask

    initial begin
        int          base_cnt;
        logic [40:0] held;
        logic [15:0] d;

        repeat (2) @(negedge clk);
        check_val("rst_fifo_wr", {63'd0, fifo_wr}, 64'd0);
        check_val("rst_host_wait", {63'd0, host_wait}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_data", {23'd0, fifo_wr_data}, 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // Single write, empty FIFO
        drive_beat(1'b0, 22'h000010, 2'b11, 16'hA5A5, 4'd1);
        check_val("single_wait", {63'd0, host_wait}, 64'd0);
        exp_q.push_back(pack(1'b0, 2'b11, 22'h000010, 16'hA5A5));
        #1;
        check_val("single_fifo_wr", {63'd0, fifo_wr}, 64'd1);
        check_val("single_data", {23'd0, fifo_wr_data}, {23'd0, 41'h0_C000_10A5A5});
        drain("single_drain");

        // Read burst of 4 across the address wrap
        burst(1'b1, 22'h3FFFFE, 4'd4, 0);
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            #1;
            check_val("rd_wait_hi", {63'd0, host_wait}, 64'd1);
        end
        idle_cycle();
        #1;
        check_val("rd_wait_lo", {63'd0, host_wait}, 64'd0);
        drain("rd4_drain");

        // Write burst of 3 with a 2-cycle gap after beat 1
        wr_beat(22'h001230, 22'h001230, 2'b01, 16'h1111, 4'd3);
        wr_beat(22'h001231, 22'h2AAAAA, 2'b10, 16'h2222, 4'd9);
        for (int k = 0; k < 2; k++) begin
            idle_cycle();
            #1;
            check_val("gap_busy", {63'd0, busy}, 64'd1);
        end
        wr_beat(22'h001232, 22'h155555, 2'b11, 16'h3333, 4'd0);
        drain("gap_drain");

        // FIFO full held for 5 cycles during a write burst
        wr_beat(22'h000200, 22'h000200, 2'b11, 16'hBEEF, 4'd3);
        held = pack(1'b0, 2'b11, 22'h000200, 16'hBEEF);
        d = 16'hC0DE;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            host_req = 1'b1; host_be = 2'b10; host_wdata = d; host_addr = 22'h0;
            fifo_full = 1'b1;
            #1;
            check_val("full_wait", {63'd0, host_wait}, 64'd1);
            check_val("full_no_wr", {63'd0, fifo_wr}, 64'd0);
            check_val("full_held", {23'd0, fifo_wr_data}, {23'd0, held});
        end
        wr_beat(22'h000201, 22'h0, 2'b10, d, 4'd0);
        wr_beat(22'h000202, 22'h0, 2'b01, 16'hF00D, 4'd0);
        drain("full_drain");

        // Burstcount 0 is a single read
        base_cnt = push_cnt;
        burst(1'b1, 22'h000100, 4'd0, 0);
        idle_cycle();
        #1;
        check_val("cnt0_wait", {63'd0, host_wait}, 64'd0);
        idle_cycle();
        #1;
        check_val("cnt0_idle", {63'd0, busy}, 64'd0);
        check_val("cnt0_pushes", {32'd0, push_cnt - base_cnt}, 64'd1);

        // Randomized bursts with FIFO back-pressure and write bubbles
        full_rand = 1'b1;
        for (int t = 0; t < 150; t++) begin
            burst(1'($urandom), ($urandom_range(0, 3) == 0) ? (22'h3FFFF8 + 22'($urandom_range(0, 7))) : 22'($urandom),
                  4'($urandom), 30);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        drain("rand_drain");

        // Reset during beat 2 of an 8-beat read
        burst(1'b1, 22'h000400, 4'd8, 0);
        idle_cycle();
        #3;
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_fifo_wr", {63'd0, fifo_wr}, 64'd0);
        check_val("rst_mid_busy", {63'd0, busy}, 64'd0);
        check_val("rst_mid_wait", {63'd0, host_wait}, 64'd0);
        exp_q.delete();
        repeat (2) idle_cycle();
        reset_n = 1'b1;
        base_cnt = push_cnt;
        wr_beat(22'h000033, 22'h000033, 2'b11, 16'h5A5A, 4'd1);
        drain("post_rst_drain");
        repeat (3) idle_cycle();
        check_val("post_rst_pushes", {32'd0, push_cnt - base_cnt}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
